// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 24;
   localparam int DEPTH      = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE_WR = 2'd1,
      ISSUE_RD = 2'd2,
      RESP     = 2'd3
   } state_e;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input grant picker with last-grant memory (round-robin on ties).
// Define ARB_FIXED_PRIO_EN to make requester A always win a tie.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    en_i,
   input  logic    req_a_i,
   input  logic    req_b_i,
   output logic    gnt_a_o,
   output logic    gnt_b_o,
   output req_id_e gnt_id_o
);

   logic gnt_a_s;
   logic gnt_b_s;

`ifdef ARB_FIXED_PRIO_EN
   logic unused_clk_rst_s;
   assign unused_clk_rst_s = clk ^ rst;

   // Fixed priority: A wins whenever it requests.
   always_comb begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
      if (!en_i) begin
         gnt_a_s = 1'b0;
      end else if (req_a_i) begin
         gnt_a_s = 1'b1;
      end else if (req_b_i) begin
         gnt_b_s = 1'b1;
      end else begin
         gnt_a_s = 1'b0;
      end
   end
`else
   req_id_e last_q;
   req_id_e last_d;

   // Tie goes to whoever was not granted last; any grant updates the record.
   always_comb begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
      last_d  = last_q;
      if (!en_i) begin
         gnt_a_s = 1'b0;
      end else if (req_a_i && req_b_i) begin
         if (last_q == REQ_B) begin
            gnt_a_s = 1'b1;
         end else begin
            gnt_b_s = 1'b1;
         end
      end else if (req_a_i) begin
         gnt_a_s = 1'b1;
      end else if (req_b_i) begin
         gnt_b_s = 1'b1;
      end else begin
         gnt_a_s = 1'b0;
      end
      if (gnt_a_s) begin
         last_d = REQ_A;
      end else if (gnt_b_s) begin
         last_d = REQ_B;
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant register; reset to B so A wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_q <= REQ_B;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign gnt_a_o  = gnt_a_s;
   assign gnt_b_o  = gnt_b_s;
   assign gnt_id_o = gnt_b_s ? REQ_B : REQ_A;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port-pair registered memory.
// ARB_FIXED_PRIO_EN selects fixed A-priority instead of round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_rsp_valid,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              mem_wren,
   output logic              mem_rden,
   output logic [ADDR_W-1:0] mem_addr_wr,
   output logic [ADDR_W-1:0] mem_addr_rd,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   state_e            state_q, state_d;
   req_id_e           id_q, id_d;
   req_id_e           gnt_id_s;
   logic              gnt_a_s, gnt_b_s, handshake_s, arb_en_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              wren_q, rden_q, a_rsp_q, b_rsp_q;
   logic [ADDR_W-1:0] addr_wr_q, addr_rd_q;
   logic [DATA_W-1:0] data_in_q, rsp_hold_q;

   // Gating with rst keeps readies low while reset is being applied.
   assign arb_en_s = (state_q == IDLE) && rst;

   rr_arb2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .en_i     (arb_en_s),
      .req_a_i  (a_valid),
      .req_b_i  (b_valid),
      .gnt_a_o  (gnt_a_s),
      .gnt_b_o  (gnt_b_s),
      .gnt_id_o (gnt_id_s)
   );

   assign handshake_s = gnt_a_s | gnt_b_s;
   assign sel_we_s    = gnt_b_s ? b_we    : a_we;
   assign sel_addr_s  = gnt_b_s ? b_addr  : a_addr;
   assign sel_wdata_s = gnt_b_s ? b_wdata : a_wdata;

   // Next-state logic: one issue cycle, plus a response cycle for reads.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (handshake_s) begin
               id_d    = gnt_id_s;
               state_d = sel_we_s ? ISSUE_WR : ISSUE_RD;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE_WR: state_d = IDLE;
         ISSUE_RD: state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State, strobes and held memory-side command registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         id_q       <= REQ_A;
         wren_q     <= 1'b0;
         rden_q     <= 1'b0;
         a_rsp_q    <= 1'b0;
         b_rsp_q    <= 1'b0;
         addr_wr_q  <= '0;
         addr_rd_q  <= '0;
         data_in_q  <= '0;
         rsp_hold_q <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         wren_q  <= (state_d == ISSUE_WR);
         rden_q  <= (state_d == ISSUE_RD);
         a_rsp_q <= (state_d == RESP) && (id_q == REQ_A);
         b_rsp_q <= (state_d == RESP) && (id_q == REQ_B);
         if (handshake_s && sel_we_s) begin
            addr_wr_q <= sel_addr_s;
            data_in_q <= sel_wdata_s;
         end
         if (handshake_s && !sel_we_s) begin
            addr_rd_q <= sel_addr_s;
         end
         if (state_q == RESP) begin
            rsp_hold_q <= mem_data_out;
         end
      end
   end

   // Memory read data arrives in RESP; it is held afterwards.
   assign rsp_data    = (state_q == RESP) ? mem_data_out : rsp_hold_q;
   assign a_ready     = gnt_a_s;
   assign b_ready     = gnt_b_s;
   assign a_rsp_valid = a_rsp_q;
   assign b_rsp_valid = b_rsp_q;
   assign mem_wren    = wren_q;
   assign mem_rden    = rden_q;
   assign mem_addr_wr = addr_wr_q;
   assign mem_addr_rd = addr_rd_q;
   assign mem_data_in = data_in_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random checks of mem_arbiter against a registered memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_ready, a_we, a_rsp_valid;
   logic        b_valid, b_ready, b_we, b_rsp_valid;
   logic [4:0]  a_addr, b_addr, mem_addr_wr, mem_addr_rd;
   logic [23:0] a_wdata, b_wdata, rsp_data, mem_data_in, mem_dout;
   logic        mem_wren, mem_rden;
   logic [23:0] mem_m [32];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(5), .DATA_W(24)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
      .rsp_data(rsp_data), .mem_wren(mem_wren), .mem_rden(mem_rden),
      .mem_addr_wr(mem_addr_wr), .mem_addr_rd(mem_addr_rd),
      .mem_data_in(mem_data_in), .mem_data_out(mem_dout)
   );

   // Memory with one-cycle registered read.
   always @(posedge clk) begin
      if (mem_wren) mem_m[mem_addr_wr] <= mem_data_in;
      if (mem_rden) mem_dout <= mem_m[mem_addr_rd];
   end

   // Exclusivity monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         n_checks++;
         if ((mem_wren && mem_rden) || (a_ready && b_ready)) begin
            $display("FAIL exclusive wren=%b rden=%b a_ready=%b b_ready=%b, required no overlap",
                     mem_wren, mem_rden, a_ready, b_ready);
            n_fail++;
         end
      end
   end

   task automatic do_write(input bit is_b, input logic [4:0] ad, input logic [23:0] wd, output bit got);
      got = 1'b0;
      if (is_b) begin b_valid = 1'b1; b_we = 1'b1; b_addr = ad; b_wdata = wd; end
      else      begin a_valid = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = wd; end
      for (int i = 0; i < 8; i++) begin
         #1;
         if (is_b ? b_ready : a_ready) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      if (got) begin @(posedge clk); #1; end
   endtask

   task automatic do_read(input bit is_b, input logic [4:0] ad, output bit got,
                          output logic a_rv, output logic b_rv, output logic [23:0] d);
      got = 1'b0; a_rv = 1'b0; b_rv = 1'b0; d = 24'h0;
      if (is_b) begin b_valid = 1'b1; b_we = 1'b0; b_addr = ad; end
      else      begin a_valid = 1'b1; a_we = 1'b0; a_addr = ad; end
      for (int i = 0; i < 8; i++) begin
         #1;
         if (is_b ? b_ready : a_ready) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      if (got) begin
         @(posedge clk); #1;
         a_rv = a_rsp_valid; b_rv = b_rsp_valid; d = rsp_data;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      a_valid = 1'b1; b_valid = 1'b1; #1;
      n_checks++;
      if ({a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_wren, mem_rden} !== 6'b0) begin
         $display("FAIL reset_ctrl got=%b required=000000",
                  {a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_wren, mem_rden});
         n_fail++;
      end
      n_checks++;
      if ({mem_addr_wr, mem_addr_rd, mem_data_in, rsp_data} !== 58'h0) begin
         $display("FAIL reset_data got=%h required=0", {mem_addr_wr, mem_addr_rd, mem_data_in, rsp_data});
         n_fail++;
      end
      a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 24'hABCDEF; #1;
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         $display("FAIL wr_ready got a=%b b=%b required a=1 b=0", a_ready, b_ready); n_fail++;
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
      n_checks++;
      if ({mem_wren, mem_rden, mem_addr_wr, mem_data_in} !== {1'b1, 1'b0, 5'd5, 24'hABCDEF}) begin
         $display("FAIL wr_issue got wren=%b rden=%b addr=%0d data=%h required 1 0 5 abcdef",
                  mem_wren, mem_rden, mem_addr_wr, mem_data_in); n_fail++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (mem_wren !== 1'b0 || mem_addr_wr !== 5'd5 || mem_data_in !== 24'hABCDEF) begin
         $display("FAIL wr_hold got wren=%b addr=%0d data=%h required 0 5 abcdef",
                  mem_wren, mem_addr_wr, mem_data_in); n_fail++;
      end
   endtask

   task automatic test_read();
      b_valid = 1'b1; b_we = 1'b0; b_addr = 5'd5; #1;
      n_checks++;
      if (b_ready !== 1'b1 || a_ready !== 1'b0) begin
         $display("FAIL rd_ready got a=%b b=%b required a=0 b=1", a_ready, b_ready); n_fail++;
      end
      @(posedge clk); #1;
      b_valid = 1'b0;
      n_checks++;
      if (mem_rden !== 1'b1 || mem_wren !== 1'b0 || mem_addr_rd !== 5'd5) begin
         $display("FAIL rd_issue got rden=%b wren=%b addr=%0d required 1 0 5", mem_rden, mem_wren, mem_addr_rd);
         n_fail++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0 || rsp_data !== 24'hABCDEF) begin
         $display("FAIL rd_resp got b_rv=%b a_rv=%b data=%h required 1 0 abcdef",
                  b_rsp_valid, a_rsp_valid, rsp_data); n_fail++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (b_rsp_valid !== 1'b0 || mem_rden !== 1'b0) begin
         $display("FAIL rd_pulse got b_rv=%b rden=%b required 0 0", b_rsp_valid, mem_rden); n_fail++;
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_b;
      logic [3:0] got_b;
      int         n_gnt;
`ifdef ARB_FIXED_PRIO_EN
      exp_b = 4'b0000;
`else
      exp_b = 4'b1010;
`endif
      got_b = 4'b0; n_gnt = 0;
      a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd10; a_wdata = 24'h111111;
      b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd11; b_wdata = 24'h222222;
      for (int i = 0; i < 24 && n_gnt < 4; i++) begin
         #1;
         if (a_ready || b_ready) begin
            got_b[n_gnt] = b_ready;
            n_gnt++;
         end
         @(posedge clk); #1;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (n_gnt != 4 || got_b !== exp_b) begin
         $display("FAIL rr_order got=%b (bit i=1 means B) grants=%0d required=%b", got_b, n_gnt, exp_b);
         n_fail++;
      end
   endtask

   task automatic test_reset_in_read();
      a_valid = 1'b1; a_we = 1'b0; a_addr = 5'd5; #1;
      n_checks++;
      if (a_ready !== 1'b1) begin
         $display("FAIL rst_rd_ready got=%b required=1", a_ready); n_fail++;
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
      n_checks++;
      if (mem_rden !== 1'b1) begin
         $display("FAIL rst_rd_issue got rden=%b required=1", mem_rden); n_fail++;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_wren, mem_rden,
           mem_addr_wr, mem_addr_rd, mem_data_in, rsp_data} !== 64'h0) begin
         $display("FAIL rst_rd_outputs got=%h required=0", {a_ready, b_ready, a_rsp_valid, b_rsp_valid,
                  mem_wren, mem_rden, mem_addr_wr, mem_addr_rd, mem_data_in, rsp_data});
         n_fail++;
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin
            $display("FAIL rst_rd_no_rsp got a=%b b=%b required 0 0", a_rsp_valid, b_rsp_valid); n_fail++;
         end
      end
      a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd20; a_wdata = 24'h000AAA;
      b_valid = 1'b1; b_we = 1'b1; b_addr = 5'd21; b_wdata = 24'h000BBB; #1;
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         $display("FAIL rst_first_tie got a=%b b=%b required a=1 b=0", a_ready, b_ready); n_fail++;
      end
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      bit          got;
      logic        a_rv, b_rv;
      logic [23:0] d;
      a_valid = 1'b1; a_we = 1'b1; a_addr = 5'd0; a_wdata = 24'h123456; #1;
      n_checks++;
      if (a_ready !== 1'b1) begin $display("FAIL b2b_g1 got=%b required=1", a_ready); n_fail++; end
      @(posedge clk); #1;
      a_addr = 5'd31; a_wdata = 24'hFEDCBA; #1;
      n_checks++;
      if (a_ready !== 1'b0 || mem_wren !== 1'b1 || mem_addr_wr !== 5'd0) begin
         $display("FAIL b2b_gap got ready=%b wren=%b addr=%0d required 0 1 0", a_ready, mem_wren, mem_addr_wr);
         n_fail++;
      end
      @(posedge clk); #1; #1;
      n_checks++;
      if (a_ready !== 1'b1) begin $display("FAIL b2b_g2 got=%b required=1", a_ready); n_fail++; end
      @(posedge clk); #1;
      a_valid = 1'b0;
      n_checks++;
      if (mem_wren !== 1'b1 || mem_addr_wr !== 5'd31 || mem_data_in !== 24'hFEDCBA) begin
         $display("FAIL b2b_w31 got wren=%b addr=%0d data=%h required 1 31 fedcba",
                  mem_wren, mem_addr_wr, mem_data_in); n_fail++;
      end
      @(posedge clk); #1;
      do_read(1'b0, 5'd0, got, a_rv, b_rv, d);
      n_checks++;
      if (!got || a_rv !== 1'b1 || b_rv !== 1'b0 || d !== 24'h123456) begin
         $display("FAIL b2b_rd0 got grant=%b a_rv=%b b_rv=%b data=%h required 1 1 0 123456", got, a_rv, b_rv, d);
         n_fail++;
      end
      do_read(1'b1, 5'd31, got, a_rv, b_rv, d);
      n_checks++;
      if (!got || a_rv !== 1'b0 || b_rv !== 1'b1 || d !== 24'hFEDCBA) begin
         $display("FAIL b2b_rd31 got grant=%b a_rv=%b b_rv=%b data=%h required 1 0 1 fedcba", got, a_rv, b_rv, d);
         n_fail++;
      end
   endtask

   task automatic test_stress();
      logic [23:0] sb [32];
      bit          sb_vld [32];
      bit          got, is_b, a_pend, b_pend, ga, gb;
      logic        a_rv, b_rv;
      logic [23:0] d, aw, bw;
      logic [4:0]  ad, bd;
      int          mode;
      for (int k = 0; k < 32; k++) sb_vld[k] = 1'b0;
      for (int it = 0; it < 60; it++) begin
         mode = int'($urandom_range(0, 3));
         is_b = 1'($urandom_range(0, 1));
         ad   = 5'($urandom_range(0, 7));
         aw   = 24'($urandom);
         if (mode == 0) begin
            bd = 5'($urandom_range(0, 7));
            bw = 24'($urandom);
            a_valid = 1'b1; a_we = 1'b1; a_addr = ad; a_wdata = aw;
            b_valid = 1'b1; b_we = 1'b1; b_addr = bd; b_wdata = bw;
            a_pend = 1'b1; b_pend = 1'b1;
            for (int i = 0; i < 12; i++) begin
               if (!a_pend && !b_pend) break;
               #1; ga = a_ready; gb = b_ready;
               @(posedge clk); #1;
               if (ga) begin a_valid = 1'b0; a_pend = 1'b0; sb[ad] = aw; sb_vld[ad] = 1'b1; end
               if (gb) begin b_valid = 1'b0; b_pend = 1'b0; sb[bd] = bw; sb_vld[bd] = 1'b1; end
            end
            a_valid = 1'b0; b_valid = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (a_pend || b_pend) begin
               $display("FAIL stress_contend pending a=%b b=%b required both granted", a_pend, b_pend);
               n_fail++;
            end
         end else if (mode == 1) begin
            do_write(is_b, ad, aw, got);
            n_checks++;
            if (!got) begin
               $display("FAIL stress_wr_grant got=0 required=1 addr=%0d", ad); n_fail++;
            end else begin
               sb[ad] = aw; sb_vld[ad] = 1'b1;
            end
         end else begin
            do_read(is_b, ad, got, a_rv, b_rv, d);
            n_checks++;
            if (!got || a_rv !== ~is_b || b_rv !== is_b || (sb_vld[ad] && d !== sb[ad])) begin
               $display("FAIL stress_rd addr=%0d got grant=%b a_rv=%b b_rv=%b data=%h required owner_b=%b data=%h",
                        ad, got, a_rv, b_rv, d, is_b, sb[ad]);
               n_fail++;
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 32; k++) mem_m[k] = 24'h0;
      mem_dout = 24'h0;
      rst = 1'b0;
      a_valid = 1'b0; a_we = 1'b0; a_addr = 5'd0; a_wdata = 24'h0;
      b_valid = 1'b0; b_we = 1'b0; b_addr = 5'd0; b_wdata = 24'h0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      mon_en = 1'b1;
      test_write();
      test_read();
      test_round_robin();
      test_reset_in_read();
      test_back_to_back();
      test_stress();
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
